// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver, 8N1 by default or 8E1 when UART_RX_PARITY_EN is defined.
// Byte lands one sysclk after the stop sample; rx_status holds until rx_ack, overrun is sticky.
module uart_receiver #(
  parameter int OVERSAMPLE_DIV = 326
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);
  localparam int DW = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(OVERSAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  logic          meta_q, sync_q, prev_q;
  logic [DW-1:0] div_q, div_d;
  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q;
  logic          status_q, ferr_q, ovr_q;
  logic          deliver;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d, perr_q;
`endif

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    div_d   = tick ? '0 : div_q + 1'b1;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Restarting the divider on the edge aligns sample ticks to the start bit.
        if (prev_q && !sync_q) begin
          state_d = START;
          div_d   = '0;
          phase_d = '0;
        end
      end
      START: begin
        if (tick) begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd7) begin
            if (sync_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              phase_d = '0;
              bit_d   = '0;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            shift_d = {sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            par_d   = ^{sync_q, shift_q};
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'd15) begin
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= uart_rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      div_q   <= div_d;
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // A delivery outranks a same-cycle ack, so that ack never counts as an overrun.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      status_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (deliver) begin
      data_q   <= shift_q;
      ferr_q   <= ~sync_q;
      status_q <= 1'b1;
      if (status_q && !rx_ack) ovr_q <= 1'b1;
    end else if (rx_ack) begin
      status_q <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      if (deliver) perr_q <= par_q;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_status = status_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
endmodule
